// File: rtl/servo_pkg.sv
// Shared servo definitions: duty-code range used by the PWM controllers and
// the pulse decoder state encoding.
package servo_pkg;

   localparam int DUTY_W   = 7;
   localparam int DUTY_MAX = 100;

   localparam int SCALE_SHIFT = 16;

   typedef enum logic [1:0] {
      ARM       = 2'd0,
      WAIT_RISE = 2'd1,
      MEASURE   = 2'd2
   } dec_state_t;

   // Fixed-point reciprocal used to turn step counts into 0..DUTY_MAX codes.
   function automatic int scale_mult(input int span);
      return (DUTY_MAX * (1 << SCALE_SHIFT) + span / 2) / span;
   endfunction

endpackage

// File: rtl/servo_input_sync.sv
// Synchronizer, optional glitch filter (SERVO_DEC_GLITCH_FILTER_EN) and
// registered edge detect for an asynchronous pulse input.
module servo_input_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [NS-1:0] sync_q;
   logic          src;
   logic          lvl_q;
   logic          prev_q;
   logic          rise_q;
   logic          fall_q;

   // Everything resets high so a pulse already in progress at reset release
   // never produces a rising edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[NS-2:0], din};
      end
   end

`ifdef SERVO_DEC_GLITCH_FILTER_EN
   localparam int FL   = (FILTER_LEN < 1) ? 1 : FILTER_LEN;
   localparam int FC_W = (FL > 1) ? $clog2(FL) : 1;

   logic            filt_q;
   logic [FC_W-1:0] filt_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filt_q   <= 1'b1;
         filt_cnt <= '0;
      end else if (sync_q[NS-1] == filt_q) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FC_W'(FL - 1)) begin
         filt_q   <= sync_q[NS-1];
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end

   assign src = filt_q;
`else
   assign src = sync_q[NS-1];
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lvl_q  <= 1'b1;
         prev_q <= 1'b1;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         lvl_q  <= src;
         prev_q <= lvl_q;
         rise_q <= lvl_q & ~prev_q;
         fall_q <= ~lvl_q & prev_q;
      end
   end

   assign level = prev_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures servo pulse high time and converts it to a 0..100 duty code.
// Optional input glitch filter: define SERVO_DEC_GLITCH_FILTER_EN.
//
// state     | meaning
// ARM       | wait for a low input so a partial pulse is never measured
// WAIT_RISE | idle between pulses, timeout counter running
// MEASURE   | counting high-time steps until the falling edge
module servo_pulse_decoder
   import servo_pkg::*;
#(
   parameter int CLKS_PER_STEP  = 1000,
   parameter int MIN_STEPS      = 100,
   parameter int SPAN_STEPS     = 100,
   parameter int MAX_HIGH_STEPS = 250,
   parameter int TIMEOUT_STEPS  = 2500,
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              servo_in,
   output logic [DUTY_W-1:0] duty_cycle,
   output logic              duty_valid,
   output logic              signal_lost,
   output logic              pulse_error
);

   localparam int PRE_W = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;
   localparam int HS_W  = $clog2(MAX_HIGH_STEPS + 2);
   localparam int D_W   = HS_W + 2;
   localparam int TO_W  = $clog2(TIMEOUT_STEPS + 1);
   localparam int MULT  = scale_mult(SPAN_STEPS);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_STEP - 1);
   localparam logic [HS_W-1:0]  HS_LIMIT = HS_W'(MAX_HIGH_STEPS);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_STEPS - 1);
   localparam logic [TO_W-1:0]  TO_FULL  = TO_W'(TIMEOUT_STEPS);

   logic              level;
   logic              rise;
   logic              fall;
   logic [PRE_W-1:0]  pre_cnt;
   logic              step_tick;
   logic [HS_W-1:0]   high_steps;
   logic [HS_W:0]     hs_eff;
   logic [TO_W-1:0]   to_cnt;
   logic              to_hit;
   logic [DUTY_W-1:0] new_code;
   logic              over_limit;
   dec_state_t        state;
   dec_state_t        state_nxt;
   logic              meas_done;
   logic              meas_err;
   logic              clear_steps;
   logic              count_steps;

   servo_input_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (servo_in),
      .level (level),
      .rise  (rise),
      .fall  (fall)
   );

   // d = steps - MIN with a sign guard bit; clamp, then scale to 0..DUTY_MAX.
   function automatic logic [DUTY_W-1:0] steps_to_code(input logic [HS_W:0] hs);
      logic signed [D_W-1:0] d;
      int                    dv;
      logic [DUTY_W-1:0]     code;
      d  = $signed({1'b0, hs}) - $signed(D_W'(MIN_STEPS));
      dv = int'(d);
      if (dv <= 0) begin
         code = '0;
      end else if (dv >= SPAN_STEPS) begin
         code = DUTY_W'(DUTY_MAX);
      end else if (SPAN_STEPS == DUTY_MAX) begin
         code = DUTY_W'(dv);
      end else begin
         code = DUTY_W'((dv * MULT) >>> SCALE_SHIFT);
      end
      return code;
   endfunction

   // Prescaler realigns to the pulse start so step boundaries track the rise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_cnt <= '0;
      end else if (rise || pre_cnt == PRE_LAST) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   assign step_tick  = (pre_cnt == PRE_LAST);
   assign over_limit = step_tick && (high_steps >= HS_LIMIT);
   assign hs_eff     = {1'b0, high_steps} + (HS_W + 1)'(step_tick);
   assign new_code   = steps_to_code(hs_eff);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ARM;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARM: begin
            if (!level) state_nxt = WAIT_RISE;
         end
         WAIT_RISE: begin
            if (rise) state_nxt = MEASURE;
         end
         MEASURE: begin
            if (over_limit) begin
               state_nxt = ARM;
            end else if (fall) begin
               state_nxt = WAIT_RISE;
            end
         end
         default: state_nxt = ARM;
      endcase
   end

   always_comb begin
      meas_done   = 1'b0;
      meas_err    = 1'b0;
      clear_steps = 1'b0;
      count_steps = 1'b0;
      case (state)
         WAIT_RISE: clear_steps = rise;
         MEASURE: begin
            meas_err    = over_limit;
            meas_done   = fall && !over_limit;
            count_steps = step_tick && !over_limit;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         high_steps <= '0;
      end else if (clear_steps) begin
         high_steps <= '0;
      end else if (count_steps) begin
         high_steps <= high_steps + 1'b1;
      end
   end

   // Steps since the most recent rise, saturating at the timeout.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt <= '0;
      end else if (rise) begin
         to_cnt <= '0;
      end else if (step_tick && to_cnt != TO_FULL) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign to_hit = step_tick && !rise && (to_cnt == TO_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         duty_cycle  <= '0;
         duty_valid  <= 1'b0;
         pulse_error <= 1'b0;
         signal_lost <= 1'b1;
      end else begin
         duty_valid  <= meas_done;
         pulse_error <= meas_err;
         if (meas_done) begin
            duty_cycle <= new_code;
         end
         if (meas_done) begin
            signal_lost <= 1'b0;
         end else if (to_hit) begin
            signal_lost <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed bench for servo_pulse_decoder with a 10-clk measurement step.
module tb_servo_pulse_decoder;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       servo_in = 1'b0;
   logic [6:0] duty_cycle;
   logic       duty_valid;
   logic       signal_lost;
   logic       pulse_error;

   int errors = 0;
   int checks = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   servo_pulse_decoder #(
      .CLKS_PER_STEP (10)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .servo_in    (servo_in),
      .duty_cycle  (duty_cycle),
      .duty_valid  (duty_valid),
      .signal_lost (signal_lost),
      .pulse_error (pulse_error)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (duty_valid) valid_cnt++;
      if (pulse_error) err_cnt++;
   end

   // Drive a level for n clocks; called at a negedge, returns at a negedge.
   task automatic hold(input logic v, input int n);
      servo_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_pulse(input int high, input int low, output int nv, output int ne);
      int v0, e0;
      v0 = valid_cnt;
      e0 = err_cnt;
      hold(1'b1, high);
      hold(1'b0, low);
      nv = valid_cnt - v0;
      ne = err_cnt - e0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      servo_in = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (duty_cycle !== 7'd0) begin
         errors++; $display("FAIL reset_duty: got %0d want 0", duty_cycle);
      end
      checks++;
      if (duty_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b want 0", duty_valid);
      end
      checks++;
      if (pulse_error !== 1'b0) begin
         errors++; $display("FAIL reset_error: got %b want 0", pulse_error);
      end
      checks++;
      if (signal_lost !== 1'b1) begin
         errors++; $display("FAIL reset_lost: got %b want 1", signal_lost);
      end
      reset = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_periodic();
      int v0, nv, ne;
      v0 = valid_cnt;
      hold(1'b1, 750);
      checks++;
      if (signal_lost !== 1'b1) begin
         errors++; $display("FAIL periodic_lost_before: got %b want 1", signal_lost);
      end
      hold(1'b1, 750);
      hold(1'b0, 18500);
      checks++;
      if (valid_cnt - v0 !== 1) begin
         errors++; $display("FAIL periodic_strobes1: got %0d want 1", valid_cnt - v0);
      end
      checks++;
      if (duty_cycle !== 7'd50) begin
         errors++; $display("FAIL periodic_code1: got %0d want 50", duty_cycle);
      end
      checks++;
      if (signal_lost !== 1'b0) begin
         errors++; $display("FAIL periodic_lost_after: got %b want 0", signal_lost);
      end
      send_pulse(1500, 500, nv, ne);
      checks++;
      if (nv !== 1 || duty_cycle !== 7'd50) begin
         errors++; $display("FAIL periodic_pulse2: strobes %0d code %0d want 1 and 50", nv, duty_cycle);
      end
   endtask

   task automatic test_code_map();
      int highs [4] = '{1000, 2000, 800, 2200};
      int exps  [4] = '{0, 100, 0, 100};
      int nv, ne;
      for (int i = 0; i < 4; i++) begin
         send_pulse(highs[i], 500, nv, ne);
         checks++;
         if (nv !== 1 || ne !== 0) begin
            errors++; $display("FAIL map_strobe_%0d: valid %0d error %0d want 1 and 0", highs[i], nv, ne);
         end
         checks++;
         if (duty_cycle !== 7'(exps[i])) begin
            errors++; $display("FAIL map_code_%0d: got %0d want %0d", highs[i], duty_cycle, exps[i]);
         end
      end
   endtask

   task automatic test_pulse_error();
      int nv, ne;
      send_pulse(2600, 500, nv, ne);
      checks++;
      if (ne !== 1) begin
         errors++; $display("FAIL error_strobe: got %0d want 1", ne);
      end
      checks++;
      if (nv !== 0) begin
         errors++; $display("FAIL error_no_valid: got %0d want 0", nv);
      end
      checks++;
      if (duty_cycle !== 7'd100) begin
         errors++; $display("FAIL error_duty_held: got %0d want 100", duty_cycle);
      end
      send_pulse(1500, 500, nv, ne);
      checks++;
      if (nv !== 1 || duty_cycle !== 7'd50) begin
         errors++; $display("FAIL error_recover: strobes %0d code %0d want 1 and 50", nv, duty_cycle);
      end
   endtask

   task automatic test_reset_mid_pulse();
      int v0, e0, nv, ne;
      hold(1'b1, 50);
      reset = 1'b0;
      hold(1'b1, 10);
      checks++;
      if (duty_cycle !== 7'd0 || signal_lost !== 1'b1) begin
         errors++; $display("FAIL midrst_values: duty %0d lost %b want 0 and 1", duty_cycle, signal_lost);
      end
      reset = 1'b1;
      v0 = valid_cnt;
      e0 = err_cnt;
      hold(1'b1, 1200);
      hold(1'b0, 500);
      checks++;
      if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin
         errors++; $display("FAIL midrst_discard: valid %0d error %0d want 0 and 0", valid_cnt - v0, err_cnt - e0);
      end
      send_pulse(1500, 500, nv, ne);
      checks++;
      if (nv !== 1 || duty_cycle !== 7'd50) begin
         errors++; $display("FAIL midrst_next: strobes %0d code %0d want 1 and 50", nv, duty_cycle);
      end
   endtask

   task automatic test_timeout();
      int nv, ne, rise_cyc, delta;
      bit seen;
      rise_cyc = cyc;
      send_pulse(1500, 100, nv, ne);
      checks++;
      if (nv !== 1 || duty_cycle !== 7'd50 || signal_lost !== 1'b0) begin
         errors++; $display("FAIL timeout_pre: strobes %0d code %0d lost %b want 1 50 0", nv, duty_cycle, signal_lost);
      end
      seen = 1'b0;
      servo_in = 1'b0;
      for (int i = 0; i < 27000 && !seen; i++) begin
         @(negedge clk);
         if (signal_lost === 1'b1) seen = 1'b1;
      end
      delta = cyc - rise_cyc;
      checks++;
      if (!seen) begin
         errors++; $display("FAIL timeout_seen: signal_lost stayed %b want 1", signal_lost);
      end else if (delta < 24990 || delta > 25030) begin
         errors++; $display("FAIL timeout_time: got %0d clk want 24990..25030", delta);
      end
      hold(1'b1, 875);
      checks++;
      if (signal_lost !== 1'b1) begin
         errors++; $display("FAIL timeout_lost_at_rise: got %b want 1", signal_lost);
      end
      hold(1'b1, 875);
      hold(1'b0, 500);
      checks++;
      if (duty_cycle !== 7'd75 || signal_lost !== 1'b0) begin
         errors++; $display("FAIL timeout_recover: code %0d lost %b want 75 and 0", duty_cycle, signal_lost);
      end
   endtask

   task automatic test_glitch();
      int v0, exp_n, exp_code;
`ifdef SERVO_DEC_GLITCH_FILTER_EN
      exp_n = 1;
      exp_code = 50;
`else
      exp_n = 3;
      exp_code = 0;
`endif
      v0 = valid_cnt;
      hold(1'b1, 500);
      hold(1'b0, 2);
      hold(1'b1, 498);
      hold(1'b0, 2);
      hold(1'b1, 498);
      hold(1'b0, 500);
      checks++;
      if (valid_cnt - v0 !== exp_n) begin
         errors++; $display("FAIL glitch_strobes: got %0d want %0d", valid_cnt - v0, exp_n);
      end
      checks++;
      if (duty_cycle !== 7'(exp_code)) begin
         errors++; $display("FAIL glitch_code: got %0d want %0d", duty_cycle, exp_code);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_periodic();
      test_code_map();
      test_pulse_error();
      test_reset_mid_pulse();
      test_timeout();
      test_glitch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/servo_pulse_decoder.md
Name: servo_pulse_decoder

Overview:
- Receive-side counterpart of the servo PWM generators.
- Measures the high time of an incoming servo-style pulse train (for example an RC receiver channel or a loop-back of a generated servo output).
- Converts each pulse into the same 7-bit 0..100 duty code the servo controllers consume, and flags lost signal and malformed pulses.
- One instance per captured channel; outputs feed the duty_cycle inputs of the controller top or the game logic.

Parameters:
- CLKS_PER_STEP, 1000: clk cycles per 10 us measurement step (100 MHz clk).
- MIN_STEPS, 100: high-time steps that map to code 0 (1.0 ms).
- SPAN_STEPS, 100: steps from code 0 to code 100 (1.0 ms to 2.0 ms).
- MAX_HIGH_STEPS, 250: high time above this is a pulse error (2.5 ms).
- TIMEOUT_STEPS, 2500: steps without a rising edge before signal_lost is raised (25 ms).
- SYNC_STAGES, 2: flops in the input synchronizer, minimum 2.
- FILTER_LEN, 4: stable-sample count for the optional glitch filter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- servo_in  in  1  asynchronous servo pulse input.
- duty_cycle  out  7  last decoded code, 0..100.
- duty_valid  out  1  one-cycle strobe when duty_cycle is updated.
- signal_lost  out  1  level; no rising edge seen within TIMEOUT_STEPS.
- pulse_error  out  1  one-cycle strobe; high time exceeded MAX_HIGH_STEPS.

Behaviour:
- Reset values (asserted reset=0, asynchronous):
  - duty_cycle=0, duty_valid=0, pulse_error=0.
  - signal_lost=1 (no signal seen yet).
  - State is ARM; the prescaler and step counters are 0.
- Input path:
  - servo_in passes through a SYNC_STAGES flop chain, then a 1-cycle registered edge detect that yields rise and fall.
  - All measurements use the synchronized level.
- Prescaler:
  - Counts 0..CLKS_PER_STEP-1 and emits step_tick on wrap.
  - Restarts at 0 on rise, so steps are aligned to the pulse start.
- FSM:
  - ARM:
    - Waits for the synchronized level to be low, so a pulse already in progress at reset is never measured.
    - Goes to WAIT_RISE when low.
  - WAIT_RISE:
    - On rise: clear high_steps, go to MEASURE.
    - The timeout counter increments per step_tick. Reaching TIMEOUT_STEPS sets signal_lost. The counter saturates and the state stays WAIT_RISE.
  - MEASURE:
    - high_steps increments per step_tick.
    - On fall: compute the code and go to WAIT_RISE.
    - If high_steps exceeds MAX_HIGH_STEPS before fall: pulse_error for 1 cycle, duty_cycle unchanged, go to ARM.
- Code arithmetic:
  - Compute d = high_steps - MIN_STEPS with 1 guard bit for the sign.
  - d<0 gives 0; d>SPAN_STEPS gives 100; otherwise d×100/SPAN_STEPS.
  - With the default SPAN_STEPS=100 the scale is identity and no divider is synthesized. A non-default SPAN_STEPS uses a constant-multiply and shift approximation, exact at 0 and 100.
- Output timing:
  - duty_cycle updates and duty_valid pulses SYNC_STAGES+2 clk cycles after the first clk edge that samples servo_in low.
  - duty_cycle holds its value between strobes.
- Timeout and signal_lost:
  - The timeout counter clears on every rise.
  - signal_lost clears in the same cycle as the next duty_valid, not at rise.
- Simultaneous events:
  - A fall coinciding with step_tick counts that tick before the code is computed.
  - A fall in the same cycle high_steps would exceed MAX_HIGH_STEPS is treated as an error.
- Reset asserted mid-pulse: immediate return to reset values. After release, the FSM returns to ARM and the partial pulse is discarded.

Optional Feature:
- Macro: SERVO_DEC_GLITCH_FILTER_EN.
- Defined:
  - After the synchronizer, the filtered level changes only after FILTER_LEN consecutive equal samples.
  - Shorter glitches are ignored.
  - Both edges are delayed by FILTER_LEN cycles, so the measured width is unchanged and output latency grows by FILTER_LEN.
- Not defined: the synchronized level drives the edge detect directly and FILTER_LEN is unused.

Decomposition:
- servo_pkg holds:
  - DUTY_W=7 and DUTY_MAX=100, shared with the servo controllers.
  - The FSM state enum (ARM, WAIT_RISE, MEASURE).
- One sub-module, servo_input_sync:
  - Contains the synchronizer, the optional glitch filter and the edge detect.
  - Outputs the level, rise and fall.
  - It is reused by future captured inputs.

Test Plan (bench overrides CLKS_PER_STEP=10, so 1 step = 10 clk):
- Periodic 1500-clk pulses, 20000-clk period -> duty_valid each period, duty_cycle=50, signal_lost clears on the first strobe.
- 1000-clk pulse -> 0. 2000-clk pulse -> 100. 800-clk pulse -> 0 (saturated). 2200-clk pulse -> 100.
- 2600-clk pulse -> one pulse_error strobe, no duty_valid, duty_cycle keeps its previous value. The next 1500-clk pulse -> 50.
- Reset released while servo_in is high for 1200 clk -> no strobe for that pulse. The following 1500-clk pulse -> 50.
- Input held low 25000 clk after a valid pulse -> signal_lost=1 at 25000 clk (±1 step) after the last rise. A 1750-clk pulse -> 75, signal_lost=0.
- With SERVO_DEC_GLITCH_FILTER_EN: 2-clk low glitches injected inside a 1500-clk pulse -> single strobe, code 50. Without the macro the same stimulus -> short-pulse codes 0 (pulse fragmented).
